// File: rtl/pd_pkg.sv
// Shared types and constants for the programmable pattern detector.
package pd_pkg;

   typedef enum logic {
      FILL  = 1'b0,
      ARMED = 1'b1
   } pd_state_e;

   // Legacy sequence 0,0,1,0,1 with the first-received symbol in bit 0
   localparam int unsigned PD_LEGACY_LEN = 5;
   localparam logic [PD_LEGACY_LEN-1:0] PD_LEGACY_PAT = 5'b10100;

   function automatic int unsigned pd_len_w(input int unsigned max_len);
      return $clog2(max_len + 1);
   endfunction

endpackage

// File: rtl/pd_match_counter.sv
// Saturating match counter; an increment beats a coincident clear (result 1).
module pd_match_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i) begin
         if (clr_i)       cnt_d = CNT_W'(1);
         else if (~&cnt_q) cnt_d = cnt_q + CNT_W'(1);
      end else if (clr_i) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pattern_det_param.sv
// Runtime-programmable sequence detector with overlap mode and match counter.
// Optional PD_MASK_EN adds a per-position don't-care mask (cfg_mask).
module pattern_det_param
   import pd_pkg::*;
#(
   parameter int unsigned SYM_W   = 1,
   parameter int unsigned MAX_LEN = 8,
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned DEF_LEN = 5,
   parameter logic [MAX_LEN*SYM_W-1:0] DEF_PAT = (MAX_LEN*SYM_W)'('h14),
   localparam int unsigned LEN_W  = pd_len_w(MAX_LEN)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     valid,
   input  logic [SYM_W-1:0]         in,
   input  logic                     mode_ovl,
   input  logic                     cfg_we,
   input  logic [LEN_W-1:0]         cfg_len,
   input  logic [MAX_LEN*SYM_W-1:0] cfg_pat,
`ifdef PD_MASK_EN
   input  logic [MAX_LEN-1:0]       cfg_mask,
`endif
   input  logic                     cnt_clr,
   output logic                     out,
   output logic [CNT_W-1:0]         match_cnt,
   output logic                     cfg_err
);

   logic [MAX_LEN-1:0][SYM_W-1:0] hist_q, hist_d, shifted;
   logic [MAX_LEN-1:0][SYM_W-1:0] pat_q, pat_d;
   logic [LEN_W-1:0]              len_q, len_d;
   logic [LEN_W-1:0]              fill_q, fill_d, fill_inc;
   pd_state_e                     state_q, state_d;
   logic                          out_q, out_d;
   logic                          err_q, err_d;
   logic [MAX_LEN-1:0]            mask;
   logic [SYM_W-1:0]              sel;
   logic                          hit, match_c, cfg_ok;

`ifdef PD_MASK_EN
   logic [MAX_LEN-1:0] mask_q, mask_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) mask_q <= '0;
      else      mask_q <= mask_d;
   end

   always_comb begin
      mask_d = mask_q;
      if (cfg_we && cfg_ok) mask_d = cfg_mask;
   end

   assign mask = mask_q;
`else
   assign mask = '0;
`endif

   assign shifted  = {hist_q[MAX_LEN-2:0], in};
   assign fill_inc = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
   assign cfg_ok   = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));

   // Pattern position k lines up with the symbol of age len-1-k (age 0 = newest)
   always_comb begin
      hit = 1'b1;
      sel = '0;
      for (int unsigned k = 0; k < MAX_LEN; k++) begin
         sel = '0;
         for (int unsigned a = 0; a < MAX_LEN; a++) begin
            if (a + k + 32'd1 == 32'(len_q)) sel = shifted[a];
         end
         if ((k < 32'(len_q)) && !mask[k] && (sel != pat_q[k])) hit = 1'b0;
      end
   end

   assign match_c = valid && !cfg_we && hit &&
                    ((state_q == ARMED) || (32'(fill_q) + 32'd1 >= 32'(len_q)));

   always_comb begin
      hist_d  = hist_q;
      pat_d   = pat_q;
      len_d   = len_q;
      fill_d  = fill_q;
      state_d = state_q;
      err_d   = err_q;
      out_d   = 1'b0;
      if (cfg_we) begin
         fill_d  = '0;
         state_d = FILL;
         if (cfg_ok) begin
            len_d = cfg_len;
            pat_d = cfg_pat;
            err_d = 1'b0;
         end else begin
            err_d = 1'b1;
         end
      end else if (valid) begin
         hist_d = shifted;
         out_d  = match_c;
         if (match_c && !mode_ovl) begin
            fill_d  = '0;
            state_d = FILL;
         end else begin
            fill_d  = fill_inc;
            state_d = (32'(fill_inc) >= 32'(len_q)) ? ARMED : FILL;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hist_q  <= '0;
         pat_q   <= DEF_PAT;
         len_q   <= LEN_W'(DEF_LEN);
         fill_q  <= '0;
         state_q <= FILL;
         out_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         hist_q  <= hist_d;
         pat_q   <= pat_d;
         len_q   <= len_d;
         fill_q  <= fill_d;
         state_q <= state_d;
         out_q   <= out_d;
         err_q   <= err_d;
      end
   end

   pd_match_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc_i (match_c),
      .clr_i (cnt_clr),
      .cnt_o (match_cnt)
   );

   assign out     = out_q;
   assign cfg_err = err_q;

endmodule

// File: tb/tb_pattern_det_param.sv
// Self-checking bench for pattern_det_param: table vectors plus corner-case sequences,
// with a queue-based scoreboard fed by an independent reference model.
module tb_pattern_det_param;

   localparam int unsigned SYM_W   = 1;
   localparam int unsigned MAX_LEN = 8;
   localparam int unsigned CNT_W   = 16;
   localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);

   logic                     clk = 1'b0;
   logic                     rst = 1'b0;
   logic                     valid = 1'b0;
   logic [SYM_W-1:0]         sym = '0;
   logic                     mode_ovl = 1'b0;
   logic                     cfg_we = 1'b0;
   logic [LEN_W-1:0]         cfg_len = '0;
   logic [MAX_LEN*SYM_W-1:0] cfg_pat = '0;
   logic [MAX_LEN-1:0]       cfg_mask = '0;
   logic                     cnt_clr = 1'b0;
   logic                     out, out2, err, err2;
   logic [CNT_W-1:0]         cnt;
   logic [1:0]               cnt2;

   always #5 clk = ~clk;

   pattern_det_param u_dut (
      .clk(clk), .rst(rst), .valid(valid), .in(sym), .mode_ovl(mode_ovl),
      .cfg_we(cfg_we), .cfg_len(cfg_len), .cfg_pat(cfg_pat),
`ifdef PD_MASK_EN
      .cfg_mask(cfg_mask),
`endif
      .cnt_clr(cnt_clr), .out(out), .match_cnt(cnt), .cfg_err(err)
   );

   pattern_det_param #(.CNT_W(2)) u_sat (
      .clk(clk), .rst(rst), .valid(valid), .in(sym), .mode_ovl(mode_ovl),
      .cfg_we(cfg_we), .cfg_len(cfg_len), .cfg_pat(cfg_pat),
`ifdef PD_MASK_EN
      .cfg_mask(cfg_mask),
`endif
      .cnt_clr(cnt_clr), .out(out2), .match_cnt(cnt2), .cfg_err(err2)
   );

   typedef struct {
      logic o;
      int   c;
      int   c2;
      logic e;
   } exp_t;

   typedef struct {
      logic v;
      logic s;
      logic ovl;
      int   exp_out;
   } vec_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model: plain list of accepted symbols since the last clear
   int         m_hist[$];
   int         m_len;
   logic [7:0] m_pat;
   logic [7:0] m_mask;
   logic       m_err;
   int         m_cnt, m_cnt2;

   function automatic void model_reset();
      m_hist.delete();
      m_len  = 5;
      m_pat  = 8'h14;
      m_mask = 8'h00;
      m_err  = 1'b0;
      m_cnt  = 0;
      m_cnt2 = 0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic cycle(input logic v, input logic s, input logic ovl, input logic we,
                        input logic clr, input logic [LEN_W-1:0] len, input logic [7:0] pat,
                        input logic [7:0] mask, input int tbl_exp);
      logic hit;
      exp_t e;
      valid = v; sym = s; mode_ovl = ovl; cfg_we = we; cnt_clr = clr;
      cfg_len = len; cfg_pat = pat; cfg_mask = mask;
      @(posedge clk);
      hit = 1'b0;
      if (we) begin
         if (len >= 1 && len <= MAX_LEN) begin
            m_len = int'(len); m_pat = pat; m_err = 1'b0;
`ifdef PD_MASK_EN
            m_mask = mask;
`endif
         end else begin
            m_err = 1'b1;
         end
         m_hist.delete();
      end else if (v) begin
         m_hist.push_back(int'(s));
         if (m_hist.size() > MAX_LEN) void'(m_hist.pop_front());
         if (m_hist.size() >= m_len) begin
            hit = 1'b1;
            for (int k = 0; k < m_len; k++)
               if (!m_mask[k] && m_hist[m_hist.size() - m_len + k] != int'(m_pat[k])) hit = 1'b0;
         end
         if (hit && !ovl) m_hist.delete();
      end
      if (hit) begin
         m_cnt  = clr ? 1 : (m_cnt == 65535 ? 65535 : m_cnt + 1);
         m_cnt2 = clr ? 1 : (m_cnt2 == 3 ? 3 : m_cnt2 + 1);
      end else if (clr) begin
         m_cnt = 0; m_cnt2 = 0;
      end
      sb.push_back('{o: hit, c: m_cnt, c2: m_cnt2, e: m_err});
      #1;
      e = sb.pop_front();
      chk("out",       32'(out),  32'(e.o));
      chk("out_sat",   32'(out2), 32'(e.o));
      chk("match_cnt", 32'(cnt),  32'(e.c));
      chk("cnt_sat",   32'(cnt2), 32'(e.c2));
      chk("cfg_err",   32'(err),  32'(e.e));
      if (tbl_exp >= 0) chk("hand_out", 32'(out), 32'(tbl_exp));
   endtask

   task automatic s1(input logic s, input logic ovl, input logic clr, input int exp_out);
      cycle(1'b1, s, ovl, 1'b0, clr, '0, 8'h00, 8'h00, exp_out);
   endtask

   task automatic cfg(input logic [LEN_W-1:0] len, input logic [7:0] pat,
                      input logic [7:0] mask, input logic clr);
      cycle(1'b1, 1'b1, 1'b1, 1'b1, clr, len, pat, mask, 0);
   endtask

   task automatic do_reset();
      valid = 1'b0; cfg_we = 1'b0; cnt_clr = 1'b0;
      rst = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out", 32'(out), 32'd0);
      chk("rst_cnt", 32'(cnt), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_cnt_sat", 32'(cnt2), 32'd0);
      @(negedge clk);
      rst = 1'b1;
   endtask

   vec_t tbl [14];

   initial begin
      // Default pattern, overlap on, with an idle gap inside the second occurrence
      tbl[0]  = '{1, 0, 1, 0}; tbl[1]  = '{1, 0, 1, 0}; tbl[2]  = '{1, 1, 1, 0};
      tbl[3]  = '{1, 0, 1, 0}; tbl[4]  = '{1, 1, 1, 1}; tbl[5]  = '{0, 1, 1, 0};
      tbl[6]  = '{1, 0, 1, 0}; tbl[7]  = '{1, 0, 1, 0}; tbl[8]  = '{0, 0, 1, 0};
      tbl[9]  = '{0, 1, 1, 0}; tbl[10] = '{0, 0, 1, 0}; tbl[11] = '{1, 1, 1, 0};
      tbl[12] = '{1, 0, 1, 0}; tbl[13] = '{1, 1, 1, 1};

      do_reset();
      for (int i = 0; i < 14; i++)
         cycle(tbl[i].v, tbl[i].s, tbl[i].ovl, 1'b0, 1'b0, '0, 8'h00, 8'h00, tbl[i].exp_out);

      // Pattern 1,1,1: overlapping then non-overlapping
      cfg(4'd3, 8'h07, 8'h00, 1'b1);
      s1(1, 1, 0, 0); s1(1, 1, 0, 0); s1(1, 1, 0, 1); s1(1, 1, 0, 1); s1(1, 1, 0, 1);
      cfg(4'd3, 8'h07, 8'h00, 1'b1);
      s1(1, 0, 0, 0); s1(1, 0, 0, 0); s1(1, 0, 0, 1); s1(1, 0, 0, 0); s1(1, 0, 0, 0);
      s1(1, 0, 0, 1);

      // Full-length pattern 1,0,1,0,0,1,0,1
      cfg(4'd8, 8'hA5, 8'h00, 1'b0);
      s1(1, 1, 0, 0); s1(0, 1, 0, 0); s1(1, 1, 0, 0); s1(0, 1, 0, 0);
      s1(0, 1, 0, 0); s1(1, 1, 0, 0); s1(0, 1, 0, 0); s1(1, 1, 0, 1);

      // Illegal lengths leave the default pattern in place
      do_reset();
      cfg(4'd0, 8'h07, 8'h00, 1'b0);
      cfg(4'd9, 8'h07, 8'h00, 1'b0);
      s1(0, 1, 0, 0); s1(0, 1, 0, 0); s1(1, 1, 0, 0); s1(0, 1, 0, 0); s1(1, 1, 0, 1);
      cfg(4'd5, 8'h14, 8'h00, 1'b0);

      // Length 1: back-to-back pulses, counter saturation, clear vs match
      cfg(4'd1, 8'h01, 8'h00, 1'b1);
      for (int i = 0; i < 6; i++) s1(1, 1, 0, 1);
      s1(1, 1, 1, 1);
      s1(0, 1, 1, 0);

      // Reset mid-stream discards the partial match
      do_reset();
      s1(0, 1, 0, 0); s1(0, 1, 0, 0); s1(1, 1, 0, 0); s1(0, 1, 0, 0);
      do_reset();
      s1(1, 1, 0, 0);
      s1(0, 1, 0, 0); s1(0, 1, 0, 0); s1(1, 1, 0, 0); s1(0, 1, 0, 0); s1(1, 1, 0, 1);

`ifdef PD_MASK_EN
      cfg(4'd5, 8'h14, 8'h04, 1'b0);
      s1(0, 1, 0, 0); s1(0, 1, 0, 0); s1(0, 1, 0, 0); s1(0, 1, 0, 0); s1(1, 1, 0, 1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
